// File: rtl/tl_line_if.sv
// TileLink UH A/D channel pair (64-bit data) between a line initiator and its target.
interface tl_line_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int SOURCE_WIDTH  = 2
);
  logic                     tl_a_valid;
  logic                     tl_a_ready;
  logic [2:0]               tl_a_opcode;
  logic [2:0]               tl_a_param;
  logic [SOURCE_WIDTH-1:0]  tl_a_source;
  logic [ADDRESS_WIDTH-1:0] tl_a_address;
  logic [2:0]               tl_a_size;
  logic [7:0]               tl_a_mask;
  logic [63:0]              tl_a_data;
  logic                     tl_a_corrupt;

  logic                     tl_d_valid;
  logic                     tl_d_ready;
  logic [2:0]               tl_d_opcode;
  logic [1:0]               tl_d_param;
  logic [SOURCE_WIDTH-1:0]  tl_d_source;
  logic [2:0]               tl_d_size;
  logic                     tl_d_denied;
  logic [63:0]              tl_d_data;
  logic                     tl_d_corrupt;

  modport master (
    output tl_a_valid, tl_a_opcode, tl_a_param, tl_a_source, tl_a_address,
           tl_a_size, tl_a_mask, tl_a_data, tl_a_corrupt,
    input  tl_a_ready,
    input  tl_d_valid, tl_d_opcode, tl_d_param, tl_d_source, tl_d_size,
           tl_d_denied, tl_d_data, tl_d_corrupt,
    output tl_d_ready
  );

  modport slave (
    input  tl_a_valid, tl_a_opcode, tl_a_param, tl_a_source, tl_a_address,
           tl_a_size, tl_a_mask, tl_a_data, tl_a_corrupt,
    output tl_a_ready,
    output tl_d_valid, tl_d_opcode, tl_d_param, tl_d_source, tl_d_size,
           tl_d_denied, tl_d_data, tl_d_corrupt,
    input  tl_d_ready
  );
endinterface

// File: rtl/tl_line_master.sv
// TileLink line initiator: 64-byte Get / PutFull bursts with source-ID allocation.
// Optional sticky D-channel error flag enabled by defining TL_LINE_MASTER_ERR_EN.
//
// state | meaning
// IDLE  | waiting for a client request; req_ready while any source is free
// GET   | presenting the single Get beat on A
// PUT   | streaming 8 PutFull beats straight from the client write stream
module tl_line_master #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int SOURCE_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic [SOURCE_WIDTH-1:0]  req_source,

  input  logic [63:0]              wdata,
  input  logic                     wdata_valid,
  output logic                     wdata_ready,

  output logic [63:0]              rdata,
  output logic                     rdata_valid,
  input  logic                     rdata_ready,
  output logic                     rdata_last,
  output logic [SOURCE_WIDTH-1:0]  rdata_source,

  output logic                     wr_done,
  output logic [SOURCE_WIDTH-1:0]  wr_done_source,
  output logic                     busy,
  output logic                     err,

  tl_line_if.master                tl
);

  localparam int NUM_SOURCES = 1 << SOURCE_WIDTH;

  typedef enum logic [1:0] {IDLE, GET, PUT} state_t;

  state_t                   state, state_next;
  logic [NUM_SOURCES-1:0]   free, free_next;
  logic [SOURCE_WIDTH-1:0]  alloc_source;
  logic [ADDRESS_WIDTH-1:0] line_addr;
  logic [SOURCE_WIDTH-1:0]  a_source;
  logic [2:0]               a_beat, a_beat_next;
  logic [2:0]               d_beat;
  logic                     accept;
  logic                     d_fire, is_read, is_ack, read_done, ack_done, complete;
  logic                     wr_done_flag;
  logic [SOURCE_WIDTH-1:0]  wr_done_id;

  // Downward scan so the lowest free index wins.
  always_comb begin
    alloc_source = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (free[i]) alloc_source = SOURCE_WIDTH'(i);
    end
  end

  assign req_source = alloc_source;

  always_comb begin
    state_next     = state;
    a_beat_next    = a_beat;
    accept         = 1'b0;
    req_ready      = 1'b0;
    wdata_ready    = 1'b0;
    tl.tl_a_valid  = 1'b0;
    tl.tl_a_opcode = 3'd4;
    case (state)
      IDLE: begin
        req_ready = |free;
        if (req_valid && req_ready) begin
          accept      = 1'b1;
          a_beat_next = '0;
          state_next  = req_write ? PUT : GET;
        end
      end
      GET: begin
        tl.tl_a_valid  = 1'b1;
        tl.tl_a_opcode = 3'd4;
        if (tl.tl_a_ready) state_next = IDLE;
      end
      PUT: begin
        tl.tl_a_valid  = wdata_valid;
        tl.tl_a_opcode = 3'd0;
        wdata_ready    = tl.tl_a_ready;
        if (wdata_valid && tl.tl_a_ready) begin
          a_beat_next = a_beat + 3'd1;
          if (a_beat == 3'd7) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tl.tl_a_param   = 3'd0;
  assign tl.tl_a_size    = 3'd6;
  assign tl.tl_a_mask    = 8'hFF;
  assign tl.tl_a_corrupt = 1'b0;
  assign tl.tl_a_source  = a_source;
  assign tl.tl_a_address = line_addr;
  assign tl.tl_a_data    = wdata;

  // D side runs independently of the A FSM; only ReadData exerts backpressure.
  assign is_read      = (tl.tl_d_opcode == 3'd1);
  assign is_ack       = (tl.tl_d_opcode == 3'd0);
  assign tl.tl_d_ready = is_read ? rdata_ready : 1'b1;
  assign d_fire       = tl.tl_d_valid && tl.tl_d_ready;
  assign rdata        = tl.tl_d_data;
  assign rdata_valid  = tl.tl_d_valid && is_read;
  assign rdata_last   = is_read && (d_beat == 3'd7);
  assign rdata_source = tl.tl_d_source;
  assign read_done    = d_fire && is_read && (d_beat == 3'd7);
  assign ack_done     = d_fire && is_ack;
  assign complete     = read_done || ack_done;

  always_comb begin
    free_next = free;
    if (accept)   free_next[alloc_source]   = 1'b0;
    if (complete) free_next[tl.tl_d_source] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      free         <= '1;
      line_addr    <= '0;
      a_source     <= '0;
      a_beat       <= '0;
      d_beat       <= '0;
      wr_done_flag <= 1'b0;
      wr_done_id   <= '0;
    end else begin
      state        <= state_next;
      free         <= free_next;
      a_beat       <= a_beat_next;
      wr_done_flag <= ack_done;
      if (accept) begin
        line_addr <= {req_addr[ADDRESS_WIDTH-1:6], 6'b0};
        a_source  <= alloc_source;
      end
      if (d_fire && is_read) d_beat <= d_beat + 3'd1;
      if (ack_done) wr_done_id <= tl.tl_d_source;
    end
  end

  assign wr_done        = wr_done_flag;
  assign wr_done_source = wr_done_id;
  assign busy           = (state != IDLE) || !(&free);

`ifdef TL_LINE_MASTER_ERR_EN
  logic err_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
    end else if (d_fire && (tl.tl_d_denied || tl.tl_d_corrupt || !(is_read || is_ack) ||
                            (complete && free[tl.tl_d_source]))) begin
      err_flag <= 1'b1;
    end
  end

  assign err = err_flag;
`else
  assign err = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{tl.tl_d_param, tl.tl_d_size, tl.tl_d_denied, tl.tl_d_corrupt, req_addr[5:0]};

endmodule

// File: tb/tb_tl_line_master.sv
// Self-checking bench for tl_line_master: directed scenarios plus a randomized
// request/response mix checked against a per-source outstanding-transaction model.
module tb_tl_line_master;
  localparam int AW = 32;
  localparam int SW = 2;
  localparam int NS = 4;
`ifdef TL_LINE_MASTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [SW-1:0] req_source;
  logic [63:0]   wdata;
  logic          wdata_valid, wdata_ready;
  logic [63:0]   rdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [SW-1:0] rdata_source;
  logic          wr_done;
  logic [SW-1:0] wr_done_source;
  logic          busy, err;

  always #5 clk = ~clk;

  tl_line_if #(.ADDRESS_WIDTH(AW), .SOURCE_WIDTH(SW)) tl ();

  tl_line_master #(.ADDRESS_WIDTH(AW), .SOURCE_WIDTH(SW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_source(req_source),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .rdata_last(rdata_last), .rdata_source(rdata_source),
    .wr_done(wr_done), .wr_done_source(wr_done_source),
    .busy(busy), .err(err),
    .tl(tl.master)
  );

  int checks = 0;
  int errors = 0;
  bit pend [NS];
  bit kind [NS];
  bit exp_err;
  logic [63:0] wd [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit any_free();
    for (int i = 0; i < NS; i++) if (!pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NS; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NS; i++) if (!pend[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status();
    check("busy", busy, any_pend());
    check("req_ready", req_ready, any_free());
    check("err", err, exp_err);
  endtask

  task automatic check_a(input logic [2:0] opc, input logic [31:0] addr, input int src);
    check("a_opcode", tl.tl_a_opcode, opc);
    check("a_address", tl.tl_a_address, {addr[31:6], 6'b0});
    check("a_source", tl.tl_a_source, src);
    check("a_size", tl.tl_a_size, 3'd6);
    check("a_mask", tl.tl_a_mask, 8'hFF);
    check("a_param", tl.tl_a_param, 3'd0);
    check("a_corrupt", tl.tl_a_corrupt, 1'b0);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] addr);
    int  src;
    int  b;
    bit  done;
    src = lowest_free();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    #1;
    check("req_ready_acc", req_ready, 1'b1);
    check("req_source", req_source, src);
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    pend[src] = 1'b1;
    kind[src] = wr;
    b = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (!wr) begin
        tl.tl_a_ready = ($urandom_range(0, 2) == 0);
        #1;
        check("get_valid", tl.tl_a_valid, 1'b1);
        if (tl.tl_a_ready) begin
          check_a(3'd4, addr, src);
          done = 1'b1;
        end
      end else begin
        wdata_valid   = ($urandom_range(0, 3) != 0);
        tl.tl_a_ready = ($urandom_range(0, 3) != 0);
        wdata         = wd[b];
        #1;
        check("put_valid", tl.tl_a_valid, wdata_valid);
        check("wdata_ready", wdata_ready, tl.tl_a_ready);
        if (wdata_valid && tl.tl_a_ready) begin
          check_a(3'd0, addr, src);
          check("a_data", tl.tl_a_data, wd[b]);
          b++;
          done = (b == 8);
        end
      end
      check("busy_a", busy, 1'b1);
      tick();
    end
    tl.tl_a_ready = 1'b0;
    wdata_valid   = 1'b0;
    check("a_complete", done, 1'b1);
    #1;
    check("a_valid_after", tl.tl_a_valid, 1'b0);
  endtask

  task automatic resp_read(input int src, input bit toggle);
    logic [63:0] d [8];
    int b;
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    tl.tl_d_valid  = 1'b1;
    tl.tl_d_opcode = 3'd1;
    tl.tl_d_source = SW'(src);
    b = 0;
    for (int cyc = 0; cyc < 200 && b < 8; cyc++) begin
      tl.tl_d_data = d[b];
      rdata_ready  = toggle ? ((cyc % 2) == 1) : ($urandom_range(0, 2) != 0);
      #1;
      check("d_ready", tl.tl_d_ready, rdata_ready);
      check("rdata_valid", rdata_valid, 1'b1);
      check("rdata", rdata, d[b]);
      check("rdata_source", rdata_source, src);
      check("rdata_last", rdata_last, b == 7);
      if (rdata_ready) b++;
      tick();
    end
    tl.tl_d_valid = 1'b0;
    rdata_ready   = 1'b0;
    check("read_beats", b, 8);
    pend[src] = 1'b0;
    #1;
    check("rdata_valid_idle", rdata_valid, 1'b0);
  endtask

  task automatic resp_ack(input int src, input bit denied);
    bit bad;
    bad = denied || !pend[src];
    tl.tl_d_valid  = 1'b1;
    tl.tl_d_opcode = 3'd0;
    tl.tl_d_source = SW'(src);
    tl.tl_d_denied = denied;
    rdata_ready    = $urandom_range(0, 1);
    #1;
    check("ack_d_ready", tl.tl_d_ready, 1'b1);
    check("ack_rvalid", rdata_valid, 1'b0);
    tick();
    tl.tl_d_valid  = 1'b0;
    tl.tl_d_denied = 1'b0;
    pend[src] = 1'b0;
    if (ERR_EN && bad) exp_err = 1'b1;
    #1;
    check("wr_done", wr_done, 1'b1);
    check("wr_done_source", wr_done_source, src);
    check("err_ack", err, exp_err);
    tick();
    check("wr_done_pulse", wr_done, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_a_valid", tl.tl_a_valid, 1'b0);
    check("rst_wdata_ready", wdata_ready, 1'b0);
    check("rst_wr_done", wr_done, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < NS; i++) pend[i] = 1'b0;
    exp_err = 1'b0;
    #1;
    check_status();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int src;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wdata = '0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    tl.tl_a_ready = 1'b0;
    tl.tl_d_valid = 1'b0; tl.tl_d_opcode = 3'd0; tl.tl_d_param = 2'd0;
    tl.tl_d_source = '0; tl.tl_d_size = 3'd6; tl.tl_d_denied = 1'b0;
    tl.tl_d_data = '0; tl.tl_d_corrupt = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < NS; i++) begin pend[i] = 1'b0; kind[i] = 1'b0; end
    for (int i = 0; i < 8; i++) wd[i] = '0;
    tick();
    tick();
    check("reset_a_valid", tl.tl_a_valid, 1'b0);
    check("reset_wdata_ready", wdata_ready, 1'b0);
    check("reset_rdata_valid", rdata_valid, 1'b0);
    check("reset_wr_done", wr_done, 1'b0);
    check_status();
    reset = 1'b0;
    tick();
    check_status();

    // Single Get, then its 8 read beats.
    do_req(1'b0, 32'h1000_0057);
    check_status();
    resp_read(0, 1'b0);
    check_status();

    // PutFull with 0x11..0x88, then AccessAck.
    for (int i = 0; i < 8; i++) wd[i] = 64'(8'h11 * (i + 1));
    do_req(1'b1, 32'h2000_0000);
    resp_ack(0, 1'b0);
    check_status();

    // Exhaust all sources, then free source 2 and reallocate it.
    for (int i = 0; i < NS; i++) do_req(1'b0, $urandom);
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_req_ready", req_ready, 1'b0);
      check("full_busy", busy, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    resp_ack(2, 1'b0);
    check_status();
    do_req(1'b0, $urandom);
    resp_read(1, 1'b1);
    resp_read(0, 1'b1);
    resp_read(3, 1'b0);
    resp_read(2, 1'b0);
    check_status();

    // Randomized mix against the outstanding-source model.
    for (int it = 0; it < 80; it++) begin
      if (any_free() && (!any_pend() || ($urandom_range(0, 1) == 1))) begin
        for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
        do_req(1'($urandom_range(0, 1)), $urandom);
      end else begin
        src = $urandom_range(0, NS - 1);
        while (!pend[src]) src = (src + 1) % NS;
        if (kind[src]) resp_ack(src, 1'b0);
        else resp_read(src, 1'b0);
      end
      check_status();
    end
    for (int i = 0; i < NS; i++) begin
      if (pend[i]) begin
        if (kind[i]) resp_ack(i, 1'b0);
        else resp_read(i, 1'b0);
      end
    end
    check_status();

    // Denied AccessAck: sticky err when the feature is built in.
    do_req(1'b0, $urandom);
    resp_ack(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("err_sticky", err, exp_err);
      tick();
    end
    check_status();
    do_reset();

    // AccessAck for a source that was never allocated.
    resp_ack(3, 1'b0);
    check_status();
    do_reset();

    // Unknown opcode is dropped without touching the free map.
    do_req(1'b0, $urandom);
    tl.tl_d_valid  = 1'b1;
    tl.tl_d_opcode = 3'd2;
    tl.tl_d_source = 2'd0;
    rdata_ready    = 1'b0;
    #1;
    check("drop_d_ready", tl.tl_d_ready, 1'b1);
    check("drop_rvalid", rdata_valid, 1'b0);
    tick();
    tl.tl_d_valid = 1'b0;
    if (ERR_EN) exp_err = 1'b1;
    #1;
    check("drop_wr_done", wr_done, 1'b0);
    check_status();
    do_reset();

    // Reset while PUT beat 4 is on the bus.
    for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = $urandom;
    tick();
    req_valid = 1'b0;
    pend[0]   = 1'b1;
    wdata_valid   = 1'b1;
    tl.tl_a_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wdata = wd[b];
      #1;
      check("mid_put_valid", tl.tl_a_valid, 1'b1);
      tick();
    end
    wdata = wd[4];
    #1;
    check("put4_valid", tl.tl_a_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("put4_rst_valid", tl.tl_a_valid, 1'b0);
    check("put4_rst_wready", wdata_ready, 1'b0);
    check("put4_rst_busy", busy, 1'b0);
    check("put4_rst_req_ready", req_ready, 1'b1);
    tick();
    reset = 1'b0;
    wdata_valid   = 1'b0;
    tl.tl_a_ready = 1'b0;
    pend[0] = 1'b0;
    #1;
    check_status();
    for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
    do_req(1'b1, $urandom);
    resp_ack(0, 1'b0);
    check_status();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tl_line_master.md
# tl_line_master

TileLink initiator that turns single cache-line (64-byte) read/write requests from a local client into TL-UH Get / PutFull bursts on a 64-bit A/D channel pair. It is the requesting end of the same TileLink link that the DDR3 memory adapter serves, and is used by DMA-style blocks (frame buffer, disk, audio) that move whole lines. It allocates source IDs, streams write beats, returns read beats with their source tag and signals write completion.

## Interface
- ADDRESS_WIDTH, 32, byte address width on TL and client side
- SOURCE_WIDTH, 2, TL source width; up to 2^SOURCE_WIDTH outstanding transactions
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid / req_ready  in/out  1  client request handshake
- req_write  in  1  1=PutFull line, 0=Get line
- req_addr  in  ADDRESS_WIDTH  byte address; bits [5:0] ignored
- wdata / wdata_valid / wdata_ready  in/in/out  64/1/1  write beat stream, 8 beats per write, low address first
- rdata / rdata_valid / rdata_ready  out/out/in  64/1/1  read beat stream
- rdata_last  out  1  high on 8th beat of a read line
- rdata_source  out  SOURCE_WIDTH  source ID of current read beat
- req_source  out  SOURCE_WIDTH  ID assigned to the request accepted this cycle
- wr_done / wr_done_source  out  1/SOURCE_WIDTH  one-cycle pulse per AccessAck
- busy  out  1  any transaction outstanding or A burst in progress
- tl_a_valid, tl_a_ready, tl_a_opcode[2:0], tl_a_param[2:0], tl_a_source, tl_a_address, tl_a_size[2:0], tl_a_mask[7:0], tl_a_data[63:0], tl_a_corrupt  A channel (out except tl_a_ready)
- tl_d_valid, tl_d_ready, tl_d_opcode, tl_d_param, tl_d_source, tl_d_size, tl_d_denied, tl_d_data, tl_d_corrupt  D channel (in except tl_d_ready)
- err  out  1  sticky error flag (only with TL_LINE_MASTER_ERR_EN)

## Operation
- Constants: tl_a_param=0, tl_a_size=6, tl_a_mask=8'hFF, tl_a_corrupt=0.
- Free-source bitmap `free[2^SOURCE_WIDTH]`, reset all ones. Allocation picks lowest-index free bit.
- A-side FSM: IDLE, GET, PUT.
  - IDLE: req_ready = |free. On req handshake: latch {req_addr[AW-1:6],6'b0} and the allocated source, clear its free bit, req_source = that ID; go GET or PUT.
  - GET: tl_a_valid=1, opcode 4, one beat; on tl_a_ready -> IDLE.
  - PUT: tl_a_valid=wdata_valid, wdata_ready=tl_a_ready, tl_a_data=wdata (combinational), opcode 0, address constant across all 8 beats; 3-bit beat counter; handshake on beat 7 -> IDLE.
- D side (independent of A FSM):
  - opcode 1 ReadData: rdata=tl_d_data, rdata_valid=tl_d_valid, tl_d_ready=rdata_ready, rdata_source=tl_d_source; 3-bit D beat counter; rdata_last when counter=7; on last handshake set free[tl_d_source].
  - opcode 0 AccessAck: tl_d_ready=1; next cycle wr_done=1, wr_done_source=source; set free bit.
  - other opcodes: tl_d_ready=1, beat dropped, no free-bit change.
- Responses may return in any order between sources; beats of one message never interleave.

## Timing
- Reset values: tl_a_valid=0, wdata_ready=0, rdata_valid=0, wr_done=0, busy=0, err=0, req_ready=1 (all sources free, FSM IDLE).
- Request accept to tl_a_valid: 1 cycle (registered FSM). Read beat latency D->rdata: 0 cycles.
- Free bit set by a D completion becomes allocatable the following cycle; allocation and a free in the same cycle both take effect.
- All sources busy: req_ready=0 until a completion; no request is dropped.
- tl_a_valid never deasserts once asserted until handshake, except PUT beats follow wdata_valid.
- Reset mid-burst: FSM to IDLE, all sources freed, counters zeroed; outstanding responses abandoned.

## Configuration
- TL_LINE_MASTER_ERR_EN defined: err set (sticky until reset) on any D beat with tl_d_denied=1, tl_d_corrupt=1, unknown opcode, or completion for a source whose free bit is already set.
- Undefined: err port tied 0, those conditions silently ignored as described above.

## Test plan
- Get 0x1000_0040 -> one A beat opcode 4, address 0x1000_0040, source 0; 8 D beats 0..7 appear on rdata with rdata_last on beat 7, source 0 freed.
- PutFull 0x2000_0000 with wdata 0x11..0x88 -> 8 A beats opcode 0, constant address, data in order; AccessAck source 0 -> wr_done pulse 1 cycle later, wr_done_source=0.
- Issue 4 Gets with SOURCE_WIDTH=2 and no responses -> sources 0,1,2,3 assigned, req_ready=0 on 5th; AccessAck/ReadData for source 2 -> next request gets source 2.
- Out-of-order: responses for sources 1 then 0, rdata_ready toggled every other cycle -> tl_d_ready tracks rdata_ready, no beat lost or duplicated.
- Reset asserted during PUT beat 4 -> tl_a_valid=0 immediately, req_ready=1, busy=0 after release.
- With TL_LINE_MASTER_ERR_EN: D beat with tl_d_denied=1 -> err=1 held until reset; without macro err=0.
